// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx; request to tx_v_o is one cycle, and the owner keeps the lock until its last frame is done.
// Backpressure: ready_and_o follows tx_ready_and_i for the owner only. Waits in e_send for as long as the owner withholds v_i.
module uart_tx_arbiter #(
  parameter int num_req_p    = 4,
  parameter int data_bits_p  = 8,
  parameter int gap_cycles_p = 0
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p-1:0]             v_i,
  input  logic [num_req_p*data_bits_p-1:0] data_i,
  input  logic [num_req_p-1:0]             last_i,
  output logic [num_req_p-1:0]             ready_and_o,
  output logic                             tx_v_o,
  output logic [data_bits_p-1:0]           tx_data_o,
  input  logic                             tx_ready_and_i,
  input  logic                             tx_done_i,
  output logic [$clog2(num_req_p)-1:0]     grant_id_o,
  output logic                             busy_o
);
  localparam int id_w  = $clog2(num_req_p);
  localparam int gap_w = (gap_cycles_p > 0) ? $clog2(gap_cycles_p + 1) : 1;

  localparam logic [1:0] e_arb  = 2'd0;
  localparam logic [1:0] e_send = 2'd1;
  localparam logic [1:0] e_wait = 2'd2;
  localparam logic [1:0] e_gap  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [id_w-1:0]  grant_q, grant_d;
  logic [id_w-1:0]  rr_ptr_q, rr_ptr_d;
  logic             last_q, last_d;
  logic [gap_w-1:0] gap_cnt_q, gap_cnt_d;

  logic             req_found;
  logic [id_w-1:0]  req_idx;
  logic [id_w-1:0]  scan_idx;
  logic             owner_v;
  logic             owner_last;
  logic [data_bits_p-1:0] owner_data;
  logic             handshake;

  // Scan from the highest offset down so the lowest offset from rr_ptr_q wins.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    scan_idx  = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (int'(rr_ptr_q) + i >= num_req_p) begin
        scan_idx = id_w'(int'(rr_ptr_q) + i - num_req_p);
      end else begin
        scan_idx = id_w'(int'(rr_ptr_q) + i);
      end
      if (v_i[scan_idx]) begin
        req_found = 1'b1;
        req_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    owner_v    = 1'b0;
    owner_last = 1'b0;
    owner_data = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (grant_q == id_w'(k)) begin
        owner_v    = v_i[k];
        owner_last = last_i[k];
        owner_data = data_i[k*data_bits_p +: data_bits_p];
      end
    end
  end

  always_comb begin
    ready_and_o = '0;
    for (int k = 0; k < num_req_p; k++) begin
      ready_and_o[k] = (state_q == e_send) && (grant_q == id_w'(k)) && tx_ready_and_i;
    end
  end

  assign tx_v_o     = (state_q == e_send) && owner_v;
  assign tx_data_o  = tx_v_o ? owner_data : '0;
  assign handshake  = tx_v_o && tx_ready_and_i;
  assign busy_o     = (state_q != e_arb);
  assign grant_id_o = grant_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    last_d    = last_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      e_arb: begin
        if (req_found) begin
          grant_d = req_idx;
          state_d = e_send;
        end
      end
      e_send: begin
        if (handshake) begin
          last_d  = owner_last;
          state_d = e_wait;
        end
      end
      e_wait: begin
        if (tx_done_i) begin
          if (!last_q) begin
            state_d = e_send;
          end else begin
            rr_ptr_d = (grant_q == id_w'(num_req_p - 1)) ? '0 : grant_q + 1'b1;
            if (gap_cycles_p == 0) begin
              state_d = e_arb;
            end else begin
              gap_cnt_d = '0;
              state_d   = e_gap;
            end
          end
        end
      end
      default: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == gap_w'(gap_cycles_p - 1)) begin
          state_d = e_arb;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_arb;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      last_q    <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      last_q    <= last_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (no gap, 5-cycle gap) driven by queued requesters and a
// simple uart_tx responder, compared every cycle against an owner/gap-counting reference model.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst   [2];
  logic [N-1:0] v     [2];
  logic [N-1:0] last  [2];
  logic [N-1:0] rdy   [2];
  logic [N*W-1:0] data [2];
  logic         txr   [2];
  logic         txd   [2];
  logic         txv   [2];
  logic         busy  [2];
  logic [W-1:0] txdat [2];
  logic [1:0]   gid   [2];

  uart_tx_arbiter #(.num_req_p(N), .data_bits_p(W), .gap_cycles_p(0)) dut0 (
    .clk_i(clk), .reset_i(rst[0]), .v_i(v[0]), .data_i(data[0]), .last_i(last[0]),
    .ready_and_o(rdy[0]), .tx_v_o(txv[0]), .tx_data_o(txdat[0]), .tx_ready_and_i(txr[0]),
    .tx_done_i(txd[0]), .grant_id_o(gid[0]), .busy_o(busy[0]));

  uart_tx_arbiter #(.num_req_p(N), .data_bits_p(W), .gap_cycles_p(5)) dut1 (
    .clk_i(clk), .reset_i(rst[1]), .v_i(v[1]), .data_i(data[1]), .last_i(last[1]),
    .ready_and_o(rdy[1]), .tx_v_o(txv[1]), .tx_data_o(txdat[1]), .tx_ready_and_i(txr[1]),
    .tx_done_i(txd[1]), .grant_id_o(gid[1]), .busy_o(busy[1]));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Requester queues, index d*N+k, entries {last, data}.
  logic [8:0] q [2*N][$];

  // Reference model: owner (-1 = none), frame outstanding, message-end flag, gap cycles left.
  int m_owner [2], m_gap [2], m_ptr [2], m_gid [2];
  bit m_frame [2], m_end [2];
  int n_owner [2], n_gap [2], n_ptr [2], n_gid [2];
  bit n_frame [2], n_end [2];
  int hs_k    [2];
  bit done_now[2];

  // uart_tx responder
  bit u_pend [2];
  int u_cnt  [2];

  bit rand_en   = 1'b0;
  bit chk_en    = 1'b0;
  int force_rdy = 1;
  int fix_delay = 2;

  function automatic int gapv(input int d);
    return (d == 0) ? 0 : 5;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push_msg(input int d, input int k, input int len);
    for (int i = 0; i < len; i++) q[d*N+k].push_back({(i == len - 1), 8'($urandom)});
  endtask

  task automatic gen_inputs();
    logic [8:0] w;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N; k++) begin
        if (rand_en && q[d*N+k].size() == 0 && ($urandom % 4 == 0))
          push_msg(d, k, 1 + int'($urandom % 3));
        if (q[d*N+k].size() > 0 && !(rand_en && ($urandom % 5 == 0))) begin
          w = q[d*N+k][0];
          v[d][k] = 1'b1;
          last[d][k] = w[8];
          data[d][k*W +: W] = w[7:0];
        end else begin
          v[d][k] = 1'b0;
          last[d][k] = 1'($urandom);
          data[d][k*W +: W] = 8'($urandom);
        end
      end
      txr[d] = (force_rdy < 0) ? ($urandom % 10 < 7) : (force_rdy != 0);
      txd[d] = u_pend[d] ? (u_cnt[d] == 0) : (rand_en && ($urandom % 10 == 0));
    end
  endtask

  task automatic model_eval();
    int own, exp_txv, exp_rdy, exp_dat, k;
    bit found;
    for (int d = 0; d < 2; d++) begin
      own = m_owner[d];
      exp_txv = 0; exp_rdy = 0; exp_dat = 0;
      if (own >= 0 && !m_frame[d] && m_gap[d] == 0) begin
        exp_txv = int'(v[d][own]);
        exp_rdy = txr[d] ? (1 << own) : 0;
        exp_dat = exp_txv ? int'(data[d][own*W +: W]) : 0;
      end
      if (chk_en) begin
        chk($sformatf("d%0d_tx_v", d), int'(txv[d]), exp_txv);
        chk($sformatf("d%0d_ready", d), int'(rdy[d]), exp_rdy);
        chk($sformatf("d%0d_tx_data", d), int'(txdat[d]), exp_dat);
        chk($sformatf("d%0d_grant_id", d), int'(gid[d]), m_gid[d]);
        chk($sformatf("d%0d_busy", d), int'(busy[d]), int'(own >= 0 || m_gap[d] > 0));
      end
      n_owner[d] = m_owner[d]; n_gap[d] = m_gap[d]; n_ptr[d] = m_ptr[d];
      n_gid[d] = m_gid[d]; n_frame[d] = m_frame[d]; n_end[d] = m_end[d];
      hs_k[d] = -1;
      done_now[d] = txd[d];
      if (rst[d]) begin
        n_owner[d] = -1; n_gap[d] = 0; n_ptr[d] = 0; n_gid[d] = 0; n_frame[d] = 0; n_end[d] = 0;
      end else if (m_gap[d] > 0) begin
        n_gap[d] = m_gap[d] - 1;
      end else if (own < 0) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          k = (m_ptr[d] + i) % N;
          if (!found && v[d][k]) begin
            found = 1'b1; n_owner[d] = k; n_gid[d] = k;
          end
        end
      end else if (!m_frame[d]) begin
        if (v[d][own] && txr[d]) begin
          hs_k[d] = own; n_frame[d] = 1'b1; n_end[d] = last[d][own];
        end
      end else if (txd[d]) begin
        n_frame[d] = 1'b0;
        if (m_end[d]) begin
          n_ptr[d] = (own + 1) % N; n_owner[d] = -1; n_gap[d] = gapv(d);
        end
      end
    end
  endtask

  task automatic commit();
    for (int d = 0; d < 2; d++) begin
      if (hs_k[d] >= 0) void'(q[d*N+hs_k[d]].pop_front());
      if (done_now[d] && u_pend[d]) u_pend[d] = 1'b0;
      if (hs_k[d] >= 0) begin
        u_pend[d] = 1'b1;
        u_cnt[d]  = (fix_delay < 0) ? int'($urandom % 4) : fix_delay;
      end else if (u_pend[d] && u_cnt[d] > 0) begin
        u_cnt[d]--;
      end
      if (rst[d]) u_pend[d] = 1'b0;
      m_owner[d] = n_owner[d]; m_gap[d] = n_gap[d]; m_ptr[d] = n_ptr[d];
      m_gid[d] = n_gid[d]; m_frame[d] = n_frame[d]; m_end[d] = n_end[d];
    end
    gen_inputs();
  endtask

  // One clock: compare at negedge, then advance model and stimulus just after posedge.
  task automatic step();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
    commit();
    cyc++;
  endtask

  task automatic wait_idle(input int d, input int budget, input string nm);
    bit idle;
    for (int n = 0; n < budget; n++) begin
      #1;
      idle = !busy[d] && !u_pend[d];
      for (int k = 0; k < N; k++) if (q[d*N+k].size() != 0) idle = 1'b0;
      if (idle) return;
      step();
    end
    chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic msg_gap(input int d, input int exp);
    int t_done;
    t_done = -1;
    push_msg(d, 1, 1);
    push_msg(d, 3, 1);
    gen_inputs();
    for (int n = 0; n < 60; n++) begin
      #1;
      if (t_done >= 0 && txv[d]) begin
        chk($sformatf("d%0d_msg_to_msg", d), cyc - t_done, exp);
        wait_idle(d, 40, "gap_drain");
        return;
      end
      if (t_done < 0 && txd[d]) t_done = cyc;
      step();
    end
    chk($sformatf("d%0d_msg_to_msg_timeout", d), 0, 1);
  endtask

  initial begin
    int nsteps;
    logic [7:0] seq [$];
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; m_owner[d] = -1; m_gap[d] = 0; m_ptr[d] = 0; m_gid[d] = 0;
      m_frame[d] = 0; m_end[d] = 0; u_pend[d] = 0; u_cnt[d] = 0;
    end
    gen_inputs();
    step();
    chk_en = 1'b1;
    step();
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_tx_v", int'(txv[0]), 0);
    chk("rst_ready", int'(rdy[0]), 0);
    chk("rst_grant_id", int'(gid[0]), 0);
    chk("rst_tx_data", int'(txdat[0]), 0);

    // Single word from requester 0.
    q[0].push_back({1'b1, 8'hA5});
    gen_inputs();
    #1;
    chk("t1_arb_ready", int'(rdy[0]), 0);
    chk("t1_arb_tx_v", int'(txv[0]), 0);
    step();
    #1;
    chk("t1_tx_v", int'(txv[0]), 1);
    chk("t1_tx_data", int'(txdat[0]), 8'hA5);
    chk("t1_ready", int'(rdy[0]), 4'b0001);
    nsteps = 0;
    while (busy[0] && nsteps < 20) begin
      step(); #1; nsteps++;
    end
    chk("t1_busy_cycles", nsteps, 4);
    q[0].push_back({1'b1, 8'h01});
    q[1].push_back({1'b1, 8'h02});
    gen_inputs();
    step(); #1;
    chk("t1_rr_ptr_grant", int'(gid[0]), 1);
    wait_idle(0, 60, "t1_drain");

    // Backpressure on requester 3, then a spurious done while idle.
    force_rdy = 0;
    q[3].push_back({1'b1, 8'h3C});
    gen_inputs();
    repeat (20) step();
    #1;
    chk("t5_bp_tx_v", int'(txv[0]), 1);
    chk("t5_bp_ready", int'(rdy[0]), 0);
    chk("t5_bp_grant", int'(gid[0]), 3);
    force_rdy = 1;
    gen_inputs();
    wait_idle(0, 40, "t5_drain");
    txd[0] = 1'b1;
    step(); #1;
    chk("t5_spurious_busy", int'(busy[0]), 0);
    chk("t5_spurious_grant", int'(gid[0]), 3);

    // Message-to-message spacing with and without the gap.
    msg_gap(0, 2);
    msg_gap(1, 7);

    // Message lock: requester 2 sends three words while requester 0 waits.
    q[2].push_back({1'b0, 8'h11});
    q[2].push_back({1'b0, 8'h22});
    q[2].push_back({1'b1, 8'h33});
    gen_inputs();
    step();
    q[0].push_back({1'b1, 8'h44});
    gen_inputs();
    for (int n = 0; n < 60 && seq.size() < 4; n++) begin
      #1;
      if (txv[0] && txr[0]) seq.push_back(txdat[0]);
      step();
    end
    chk("t3_words", seq.size(), 4);
    if (seq.size() == 4) begin
      chk("t3_w0", int'(seq[0]), 8'h11);
      chk("t3_w1", int'(seq[1]), 8'h22);
      chk("t3_w2", int'(seq[2]), 8'h33);
      chk("t3_w3", int'(seq[3]), 8'h44);
    end
    wait_idle(0, 40, "t3_drain");

    // Reset during the second word; rr pointer must return to 0.
    q[2].push_back({1'b1, 8'h55});
    gen_inputs();
    wait_idle(0, 40, "t6_pre");
    q[2].push_back({1'b0, 8'h66});
    q[2].push_back({1'b0, 8'h77});
    q[2].push_back({1'b1, 8'h88});
    gen_inputs();
    nsteps = 0;
    #1;
    while (!(txv[0] && txdat[0] == 8'h77) && nsteps < 40) begin
      step(); #1; nsteps++;
    end
    chk("t6_reach_word2", int'(txv[0] && txdat[0] == 8'h77), 1);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    for (int k = 0; k < N; k++) q[k].delete();
    gen_inputs();
    #1;
    chk("t6_busy", int'(busy[0]), 0);
    chk("t6_tx_v", int'(txv[0]), 0);
    chk("t6_ready", int'(rdy[0]), 0);
    chk("t6_grant_id", int'(gid[0]), 0);
    q[1].push_back({1'b1, 8'h99});
    q[3].push_back({1'b1, 8'hAA});
    gen_inputs();
    step(); #1;
    chk("t6_rearb_grant", int'(gid[0]), 1);
    wait_idle(0, 40, "t6_drain");

    // Randomized traffic on both instances.
    rand_en = 1'b1; force_rdy = -1; fix_delay = -1;
    repeat (3000) step();
    rand_en = 1'b0; force_rdy = 1;
    gen_inputs();
    wait_idle(0, 400, "rand_drain0");
    wait_idle(1, 400, "rand_drain1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter among `num_req_p` byte-stream requesters. Each requester sends a message: one or more data words, with the final word flagged by `last_i`. A granted requester holds the transmitter until its last word's frame has completed. The block sits between the on-board producers (debug console, status reporter, etc.) and the single `uart_tx` instance driving the board TX pin.

## Interface
Parameters:
- `num_req_p`, 4 — number of requesters (≥2)
- `data_bits_p`, 8 — word width; must match the attached `uart_tx`
- `gap_cycles_p`, 0 — idle clock cycles enforced after every message before the next arbitration; 0 disables the gap

Ports:
- `clk_i`  in  1  — single clock; all state updates on its rising edge
- `reset_i`  in  1  — synchronous, active-high reset
- `v_i`  in  num_req_p  — per-requester word valid
- `data_i`  in  num_req_p*data_bits_p  — requester k occupies `[k*data_bits_p +: data_bits_p]`
- `last_i`  in  num_req_p  — word is the final word of the message; qualified by `v_i`
- `ready_and_o`  out  num_req_p  — per-requester accept; a word transfers when `v_i[k] & ready_and_o[k]`
- `tx_v_o`  out  1  — to `uart_tx.tx_v_i`
- `tx_data_o`  out  data_bits_p  — to `uart_tx.tx_i`
- `tx_ready_and_i`  in  1  — from `uart_tx.tx_ready_and_o`
- `tx_done_i`  in  1  — from `uart_tx.tx_done_o`; one-cycle frame-complete pulse
- `grant_id_o`  out  clog2(num_req_p)  — index of the current or last owner
- `busy_o`  out  1  — high in every state except `e_arb`

## Operation

**Registered state:**
- `state_r`
- `grant_r`
- `rr_ptr_r` — the highest-priority index
- `last_r`
- `gap_cnt_r`, width clog2(gap_cycles_p+1)

**States:**
- `e_arb`
  - Find the first k with `v_i[k]`=1, scanning `rr_ptr_r`, `rr_ptr_r+1`, … modulo `num_req_p`.
  - If one is found: `grant_r`←k, next state `e_send`.
  - No transfer occurs in `e_arb`: `ready_and_o`=0 and `tx_v_o`=0.
- `e_send`
  - `tx_v_o`=`v_i[grant_r]`.
  - `tx_data_o`=`data_i[grant_r]`.
  - `ready_and_o[grant_r]`=`tx_ready_and_i`; all other ready bits are 0.
  - On a handshake (`v_i[grant_r] & tx_ready_and_i`): `last_r`←`last_i[grant_r]`, next state `e_wait`.
- `e_wait`
  - `tx_v_o`=0 and `ready_and_o`=0.
  - On `tx_done_i`, if `last_r`=0: return to `e_send`. The grant stays locked to the same requester.
  - On `tx_done_i`, if `last_r`=1: `rr_ptr_r`←(`grant_r`+1) mod `num_req_p`.
    - If `gap_cycles_p`=0, go to `e_arb`.
    - Otherwise clear `gap_cnt_r` and go to `e_gap`.
- `e_gap`
  - Outputs are idle.
  - `gap_cnt_r` increments each cycle.
  - When `gap_cnt_r`=`gap_cycles_p`-1, go to `e_arb`.

**Outputs and edge cases:**
- When `tx_v_o`=0, `tx_data_o` is 0. `grant_id_o`=`grant_r` at all times.
- Only the granted requester ever sees `ready_and_o` high. Other requesters must hold `v_i`/`data_i` stable until accepted.
- The owner drops `v_i` mid-message: the arbiter waits in `e_send` indefinitely with the lock held. There is no timeout.
- `tx_done_i` outside `e_wait` is ignored.
- `v_i` with no `last_i` for a non-owner has no effect until that requester is granted.
- `rr_ptr_r` advances only on message completion, never per word.

## Timing

**Reset values** (the cycle after `reset_i` is sampled high):
- Registers: `state_r`=`e_arb`, `grant_r`=0, `rr_ptr_r`=0, `last_r`=0, `gap_cnt_r`=0.
- Outputs: `tx_v_o`=0, `tx_data_o`=0, `ready_and_o`=0, `grant_id_o`=0, `busy_o`=0.
- Reset mid-message abandons the message; no partial state is retained.

**Latency and throughput:**
- Request to `tx_v_o`: `v_i` high in `e_arb` at cycle t gives `tx_v_o`=1 at t+1, provided `tx_ready_and_i`=1.
- Word to word within a message: `tx_done_i` at cycle t gives the next `tx_v_o` at t+1.
- Message to message: `tx_done_i` of the last word at t, then `e_arb` at t+1, then the next `tx_v_o` at t+2+`gap_cycles_p`.

**Output timing:**
- `tx_v_o` and `ready_and_o` are combinational from `v_i`, `tx_ready_and_i` and `state_r`, with no combinational path from `data_i`.
- The handshake and the state change occur on the same rising edge.

## Test plan
1. **Single word.** After reset, `v_i`=0001, `data_i[0]`=0xA5, `last_i[0]`=1.
   - Required: grant 0; `tx_v_o`=1 with `tx_data_o`=0xA5 one cycle later; `ready_and_o[0]` pulses once.
   - `busy_o` stays high until the cycle after `tx_done_i`; `rr_ptr_r` ends at 1.
2. **Round robin.** All four requesters continuously valid with single-word messages.
   - Required: grant order 0,1,2,3,0,1.
   - Exactly one `ready_and_o` bit is high per handshake; no requester is starved.
3. **Message lock.** Requester 2 sends 0x11, 0x22, 0x33 (`last_i` on 0x33) while requester 0 is valid.
   - Required: UART sees 0x11, 0x22, 0x33 back-to-back; `grant_id_o` stays 2.
   - Requester 0 is granted only after the third `tx_done_i`.
4. **Inter-message gap.** `gap_cycles_p`=5, two single-word messages from requesters 1 and 3.
   - Required: exactly 5 cycles of `e_gap` (`busy_o`=1, `tx_v_o`=0) between the first `tx_done_i`+1 and `e_arb`.
5. **Backpressure and spurious done.** Hold `tx_ready_and_i`=0 for 20 cycles while granted; pulse `tx_done_i` while in `e_arb`.
   - Required: no handshake until ready rises; the spurious done causes no state change.
6. **Reset mid-message.** Assert `reset_i` during the second word of a 3-word message.
   - Required: all outputs take their reset values the next cycle.
   - A fresh request then arbitrates from `rr_ptr_r`=0.
